// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 single-wire host: FSM state codes,
// frame geometry and the frame checksum rule.
package dht11_pkg;

    localparam int FRAME_BITS = 40;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_START     = 3'd1;
    localparam state_t ST_RELEASE   = 3'd2;
    localparam state_t ST_SYNC_LOW  = 3'd3;
    localparam state_t ST_SYNC_HIGH = 3'd4;
    localparam state_t ST_DATA_LOW  = 3'd5;
    localparam state_t ST_DATA_HIGH = 3'd6;
    localparam state_t ST_CHECK     = 3'd7;

    // Byte 4 must equal the 8-bit wrapped sum of bytes 0..3 (byte 0 = MSB end).
    function automatic logic checksum_ok(input logic [FRAME_BITS-1:0] frame);
        logic [7:0] sum;
        sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
        return (sum == frame[7:0]);
    endfunction

endpackage

// File: rtl/tick_us_gen.sv
// Free-running one-clock pulse every microsecond, derived from CLK_FREQ.
module tick_us_gen #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int            DIV  = CLK_FREQ / 1_000_000;
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Divider: wrap at LAST and emit the tick on the wrap cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == LAST) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/dht11_controller.sv
// DHT11 host: issues the start pulse, captures the 40-bit frame, verifies the
// checksum and publishes the integer humidity and temperature bytes.
module dht11_controller
    import dht11_pkg::*;
#(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int START_LOW_US  = 18_000,
    parameter int RELEASE_US    = 30,
    parameter int BIT_THRESH_US = 50,
    parameter int TIMEOUT_US    = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    inout  wire        dht_io,
    output logic [7:0] humiData,
    output logic [7:0] tempData,
    output logic       valid,
    output logic       busy,
    output logic       checksum_err,
    output logic       timeout_err
);
    localparam logic [15:0] START_LAST   = 16'(START_LOW_US - 1);
    localparam logic [15:0] RELEASE_LAST = 16'(RELEASE_US - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_US - 1);
    localparam logic [15:0] BIT_THRESH   = 16'(BIT_THRESH_US);
    localparam logic [5:0]  LAST_BIT     = 6'(FRAME_BITS - 1);

    state_t                state_r, state_next_s;
    logic                  tick_s;
    logic [1:0]            sync_r;
    logic                  line_prev_r;
    logic                  rise_s, fall_s, edge_s;
    logic                  wait_state_s, timeout_s, shift_en_s, cnt_clear_s;
    logic                  seen_rise_r;
    logic [15:0]           us_cnt_r;
    logic [5:0]            bit_cnt_r;
    logic [FRAME_BITS-1:0] frame_r;
    logic                  drive_low_r;
    logic [7:0]            humi_r, temp_r;
    logic                  valid_r, busy_r, checksum_err_r, timeout_err_r;

    tick_us_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

    // Open-drain: the host only ever pulls low or lets the pull-up win.
    assign dht_io = drive_low_r ? 1'b0 : 1'bz;

    assign rise_s = sync_r[1] & ~line_prev_r;
    assign fall_s = ~sync_r[1] & line_prev_r;
    assign edge_s = rise_s | fall_s;

    // Two-flop synchronizer plus edge-detect history; idle line reads high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r      <= 2'b11;
            line_prev_r <= 1'b1;
        end else begin
            sync_r      <= {sync_r[0], dht_io};
            line_prev_r <= sync_r[1];
        end
    end

    // Next-state logic; any sensor-wait state aborts if no edge within TIMEOUT_US.
    always_comb begin
        state_next_s = state_r;
        shift_en_s   = 1'b0;
        wait_state_s = 1'b0;
        timeout_s    = 1'b0;
        cnt_clear_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_START;
                else       state_next_s = ST_IDLE;
            end
            ST_START: begin
                if (tick_s && (us_cnt_r == START_LAST)) state_next_s = ST_RELEASE;
                else                                    state_next_s = ST_START;
            end
            ST_RELEASE: begin
                if (tick_s && (us_cnt_r == RELEASE_LAST)) state_next_s = ST_SYNC_LOW;
                else                                      state_next_s = ST_RELEASE;
            end
            ST_SYNC_LOW: begin
                wait_state_s = 1'b1;
                if (fall_s) state_next_s = ST_SYNC_HIGH;
                else        state_next_s = ST_SYNC_LOW;
            end
            ST_SYNC_HIGH: begin
                wait_state_s = 1'b1;
                if (fall_s && seen_rise_r) state_next_s = ST_DATA_LOW;
                else                       state_next_s = ST_SYNC_HIGH;
            end
            ST_DATA_LOW: begin
                wait_state_s = 1'b1;
                if (rise_s) state_next_s = ST_DATA_HIGH;
                else        state_next_s = ST_DATA_LOW;
            end
            ST_DATA_HIGH: begin
                wait_state_s = 1'b1;
                if (fall_s) begin
                    shift_en_s = 1'b1;
                    if (bit_cnt_r == LAST_BIT) state_next_s = ST_CHECK;
                    else                       state_next_s = ST_DATA_LOW;
                end else begin
                    state_next_s = ST_DATA_HIGH;
                end
            end
            ST_CHECK: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        if (wait_state_s && !edge_s && tick_s && (us_cnt_r == TIMEOUT_LAST)) begin
            timeout_s    = 1'b1;
            state_next_s = ST_IDLE;
        end else begin
            timeout_s    = 1'b0;
        end
        cnt_clear_s = (state_next_s != state_r) || (wait_state_s && edge_s);
    end

    // FSM state, shared microsecond counter (also the bit high-width), shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            us_cnt_r    <= 16'd0;
            seen_rise_r <= 1'b0;
            bit_cnt_r   <= 6'd0;
            frame_r     <= '0;
            drive_low_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            drive_low_r <= (state_next_s == ST_START);
            busy_r      <= (state_next_s != ST_IDLE);
            if (cnt_clear_s) begin
                us_cnt_r <= 16'd0;
            end else if (tick_s && (us_cnt_r != 16'hFFFF)) begin
                us_cnt_r <= us_cnt_r + 16'd1;
            end
            if (state_r != ST_SYNC_HIGH) begin
                seen_rise_r <= 1'b0;
            end else if (rise_s) begin
                seen_rise_r <= 1'b1;
            end
            if (state_r == ST_IDLE) begin
                bit_cnt_r <= 6'd0;
                frame_r   <= '0;
            end else if (shift_en_s) begin
                bit_cnt_r <= bit_cnt_r + 6'd1;
                frame_r   <= {frame_r[FRAME_BITS-2:0], (us_cnt_r > BIT_THRESH)};
            end
        end
    end

    // Result publication: data bytes update only on a clean checksum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            humi_r         <= 8'd0;
            temp_r         <= 8'd0;
            valid_r        <= 1'b0;
            checksum_err_r <= 1'b0;
            timeout_err_r  <= 1'b0;
        end else begin
            valid_r        <= 1'b0;
            checksum_err_r <= 1'b0;
            timeout_err_r  <= timeout_s;
            if (state_r == ST_CHECK) begin
                if (checksum_ok(frame_r)) begin
                    humi_r  <= frame_r[39:32];
                    temp_r  <= frame_r[23:16];
                    valid_r <= 1'b1;
                end else begin
                    checksum_err_r <= 1'b1;
                end
            end
        end
    end

    assign humiData     = humi_r;
    assign tempData     = temp_r;
    assign valid        = valid_r;
    assign busy         = busy_r;
    assign checksum_err = checksum_err_r;
    assign timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_dht11_controller.sv
// Bench for dht11_controller: sensor BFM on a pulled-up line, outcome model
// driven by the frame contents, and a per-cycle compare of the published data.
`timescale 1ns/1ps
module tb_dht11_controller;

    localparam int CLK_FREQ      = 4_000_000;
    localparam int START_LOW_US  = 100;
    localparam int RELEASE_US    = 30;
    localparam int BIT_THRESH_US = 50;
    localparam int TIMEOUT_US    = 200;
    localparam int CLK_PER_US    = CLK_FREQ / 1_000_000;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    wire        dht_io;
    logic [7:0] humiData, tempData;
    logic       valid, busy, checksum_err, timeout_err;
    logic       bfm_low;

    pullup (dht_io);
    assign dht_io = bfm_low ? 1'b0 : 1'bz;

    always #125 clk = ~clk;

    dht11_controller #(
        .CLK_FREQ      (CLK_FREQ),
        .START_LOW_US  (START_LOW_US),
        .RELEASE_US    (RELEASE_US),
        .BIT_THRESH_US (BIT_THRESH_US),
        .TIMEOUT_US    (TIMEOUT_US)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .dht_io       (dht_io),
        .humiData     (humiData),
        .tempData     (tempData),
        .valid        (valid),
        .busy         (busy),
        .checksum_err (checksum_err),
        .timeout_err  (timeout_err)
    );

    int         n_checks = 0;
    int         n_err    = 0;
    int         vcnt = 0, ccnt = 0, tcnt = 0;
    bit         settle = 1'b1;
    logic [7:0] exp_humi = 8'd0;
    logic [7:0] exp_temp = 8'd0;
    logic       prev_v = 1'b0, prev_c = 1'b0, prev_t = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Outcome of a transaction from the frame alone: 0 valid, 1 checksum error, 2 timeout.
    function automatic int model_outcome(input logic [39:0] f, input int nbits);
        int s;
        if (nbits < 40) return 2;
        s = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
        return (s == int'(f[7:0])) ? 0 : 1;
    endfunction

    // Per-cycle compare: held data against the model, pulse widths, stray pulses.
    always @(negedge clk) begin
        if (!settle) begin
            n_checks++;
            if (humiData !== exp_humi || tempData !== exp_temp) begin
                n_err++;
                $display("FAIL data_hold: got humi=%0d temp=%0d, expected humi=%0d temp=%0d (t=%0t)",
                         humiData, tempData, exp_humi, exp_temp, $time);
            end
            n_checks++;
            if ({valid, checksum_err, timeout_err} !== 3'b000) begin
                n_err++;
                $display("FAIL stray_pulse: got v/c/t=%b%b%b, expected 000 (t=%0t)",
                         valid, checksum_err, timeout_err, $time);
            end
        end
        if (valid === 1'b1) begin
            n_checks++;
            if (prev_v === 1'b1) begin n_err++; $display("FAIL valid_width: got 2+ cycles, expected 1"); end
            vcnt++;
        end
        if (checksum_err === 1'b1) begin
            n_checks++;
            if (prev_c === 1'b1) begin n_err++; $display("FAIL cerr_width: got 2+ cycles, expected 1"); end
            ccnt++;
        end
        if (timeout_err === 1'b1) begin
            n_checks++;
            if (prev_t === 1'b1) begin n_err++; $display("FAIL terr_width: got 2+ cycles, expected 1"); end
            tcnt++;
        end
        prev_v = valid;
        prev_c = checksum_err;
        prev_t = timeout_err;
    end

    task automatic wait_us(input int n);
        #(n * 1000);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_line(input logic lvl, input int max_clk, output bit ok, output realtime t);
        ok = 1'b0;
        t  = 0.0;
        for (int k = 0; k <= max_clk; k++) begin
            if (dht_io === lvl) begin ok = 1'b1; t = $realtime; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_pulse(input int kind, input int max_clk, output realtime t_hit);
        int v0, c0, t0;
        bit hit;
        v0 = vcnt; c0 = ccnt; t0 = tcnt; hit = 1'b0;
        for (int k = 0; k < max_clk && !hit; k++) begin
            @(negedge clk); #1;
            if (vcnt != v0 || ccnt != c0 || tcnt != t0) hit = 1'b1;
        end
        t_hit = $realtime;
        check("outcome_seen", 32'(hit), 32'd1);
        check("valid_pulses", vcnt - v0, 32'(kind == 0));
        check("checksum_err_pulses", ccnt - c0, 32'(kind == 1));
        check("timeout_err_pulses", tcnt - t0, 32'(kind == 2));
    endtask

    task automatic reset_mid();
        settle = 1'b1;
        #37;
        reset = 1'b0;
        #1;
        check("rst_line_released", 32'(dht_io), 32'd1);
        check("rst_humi", 32'(humiData), 32'd0);
        check("rst_temp", 32'(tempData), 32'd0);
        check("rst_pulses_busy", 32'({valid, busy, checksum_err, timeout_err}), 32'd0);
        exp_humi = 8'd0;
        exp_temp = 8'd0;
        bfm_low  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("idle_after_reset", 32'(busy), 32'd0);
        settle = 1'b0;
    endtask

    // One transaction. nbits<0: silent sensor. mode 1: extra start in DATA_HIGH,
    // mode 2: reset during DATA_HIGH of bit 10.
    task automatic txn(input logic [39:0] f, input int nbits, input int mode);
        bit      ok;
        realtime t_fall, t_rel, t_now;
        int      hi, kind;
        kind = model_outcome(f, nbits);
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        wait_line(1'b0, 8, ok, t_fall);
        check("host_low_seen", 32'(ok), 32'd1);
        wait_line(1'b1, (START_LOW_US + 5) * CLK_PER_US, ok, t_rel);
        check("host_release_seen", 32'(ok), 32'd1);
        check_range("start_low_ns", int'(t_rel - t_fall),
                    (START_LOW_US - 1) * 1000 - 250, START_LOW_US * 1000 + 250);
        if (nbits < 0) begin
            settle = 1'b1;
            wait_pulse(2, (RELEASE_US + TIMEOUT_US + 20) * CLK_PER_US, t_now);
            check_range("timeout_latency_ns", int'(t_now - t_rel),
                        (RELEASE_US + TIMEOUT_US - 2) * 1000, (RELEASE_US + TIMEOUT_US + 3) * 1000);
        end else begin
            wait_us(40); bfm_low = 1'b1;
            wait_us(80); bfm_low = 1'b0;
            wait_us(80);
            for (int i = 0; i < nbits; i++) begin
                hi = f[39 - i] ? 75 : 25;
                bfm_low = 1'b1; wait_us(10); bfm_low = 1'b0;
                if (mode == 1 && i == 5) begin
                    wait_us(5);
                    pulse_start();
                    #1;
                    check("busy_ignores_start", 32'(busy), 32'd1);
                    wait_us(hi - 6);
                end else if (mode == 2 && i == 10) begin
                    wait_us(5);
                    reset_mid();
                    return;
                end else begin
                    wait_us(hi);
                end
            end
            settle = 1'b1;
            if (nbits == 40) bfm_low = 1'b1;
            wait_pulse(kind, (TIMEOUT_US + 20) * CLK_PER_US, t_now);
            bfm_low = 1'b0;
        end
        if (kind == 0) begin
            exp_humi = f[39:32];
            exp_temp = f[23:16];
        end
        @(negedge clk); #1;
        check("busy_falls", 32'(busy), 32'd0);
        @(negedge clk);
        settle = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        bfm_low = 1'b0;
        #20;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("reset_humi", 32'(humiData), 32'd0);
        check("reset_temp", 32'(tempData), 32'd0);
        check("reset_flags", 32'({valid, busy, checksum_err, timeout_err}), 32'd0);
        check("reset_line", 32'(dht_io), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        settle = 1'b0;

        txn(40'h37_00_19_00_50, 40, 0);
        check("t1_humi", 32'(humiData), 32'd55);
        check("t1_temp", 32'(tempData), 32'd25);

        txn(40'h37_00_19_00_51, 40, 0);
        check("t2_humi_hold", 32'(humiData), 32'd55);
        check("t2_temp_hold", 32'(tempData), 32'd25);

        txn(40'h0, -1, 0);
        check("t3_humi_hold", 32'(humiData), 32'd55);
        check("t3_busy", 32'(busy), 32'd0);

        txn(40'h3C_00_1A_00_56, 17, 0);
        check("t4_humi_hold", 32'(humiData), 32'd55);
        txn(40'h3C_00_1A_00_56, 40, 0);
        check("t4_retry_humi", 32'(humiData), 32'd60);
        check("t4_retry_temp", 32'(tempData), 32'd26);

        txn(40'hF0_20_10_05_25, 40, 1);
        check("t5_humi", 32'(humiData), 32'd240);
        check("t5_temp", 32'(tempData), 32'd16);

        txn(40'h2D_00_1E_00_4B, 40, 2);
        txn(40'h2D_00_1E_00_4B, 40, 0);
        check("t6_recover_humi", 32'(humiData), 32'd45);
        check("t6_recover_temp", 32'(tempData), 32'd30);

        pulse_start();
        wait_us(20);
        check("start_drives_low", 32'(dht_io), 32'd0);
        reset_mid();
        wait_us(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #40_000_000;
        n_err++;
        $display("FAIL watchdog: got no completion by %0t, expected finish earlier", $time);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
